// File: rtl/grf_pkg.sv
// Shared constants and types for the GRF write-back arbiter.
package grf_pkg;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int NREQ       = 3;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MDU    = 2;
    localparam int SCRUB_LAST = 31;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/grf_wb_grant.sv
// One-hot grant selection for the GRF write-back arbiter.
// Define GRF_WB_RR_EN for round-robin from ptr; otherwise fixed priority with index 0 highest.
module grf_wb_grant
    import grf_pkg::*;
#(
    parameter int N  = NREQ,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

`ifdef GRF_WB_RR_EN
    logic [PW-1:0] idx;
    logic          found;

    // Walk the requesters starting at ptr and take the first valid one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Isolate the lowest set bit of valid.
    assign grant = valid & (~valid + N'(1));
`endif

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter for the GRF: scrubs registers 1..31 after reset or clr_req, then grants one requester per cycle.
// Define GRF_WB_RR_EN to switch from fixed priority to round-robin arbitration.
module grf_wb_arbiter #(
    parameter int AW   = grf_pkg::AW,
    parameter int DW   = grf_pkg::DW,
    parameter int NREQ = grf_pkg::NREQ
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clr_req,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*DW-1:0] req_pc,
    output logic               WE,
    output logic [AW-1:0]      RW,
    output logic [DW-1:0]      WD,
    output logic [DW-1:0]      WPC,
    output logic               busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    grf_pkg::state_t state;
    logic [AW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [DW-1:0]   sel_pc;
    logic            accept;
    logic            xfer;

    grf_wb_grant #(
        .N  (NREQ),
        .PW (PW)
    ) u_grant (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // busy stays high for one RUN cycle after the last scrub write, so grants wait for it to drop.
    assign accept    = (state == grf_pkg::RUN) && !busy && !clr_req;
    assign req_ready = accept ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_pc   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gnt_idx  = PW'(k);
                sel_addr = req_addr[k*AW +: AW];
                sel_data = req_data[k*DW +: DW];
                sel_pc   = req_pc[k*DW +: DW];
            end
        end
    end

`ifdef GRF_WB_RR_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    // Scrub writes zero to one register per cycle; RUN forwards the granted request one cycle later.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= grf_pkg::CLEAR;
            cnt   <= AW'(1);
            WE    <= 1'b0;
            RW    <= '0;
            WD    <= '0;
            WPC   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                grf_pkg::CLEAR: begin
                    WE   <= 1'b1;
                    RW   <= cnt;
                    WD   <= '0;
                    WPC  <= '0;
                    busy <= 1'b1;
                    if (clr_req) begin
                        cnt <= AW'(1);
                    end else if (cnt == AW'(grf_pkg::SCRUB_LAST)) begin
                        state <= grf_pkg::RUN;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    if (clr_req) begin
                        state <= grf_pkg::CLEAR;
                        cnt   <= AW'(1);
                        WE    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        WE   <= xfer && (sel_addr != '0);
                        if (xfer) begin
                            RW  <= sel_addr;
                            WD  <= sel_data;
                            WPC <= sel_pc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
- REQ-001 Parameter AW, 5: GRF register address width.
- REQ-002 Parameter DW, 32: GRF data and PC width.
- REQ-003 Parameter NREQ, 3: number of write-back requesters; index 0 = ALU, 1 = LOAD, 2 = MDU.
- REQ-004 Port Clk, in, 1: single clock; all state updates on the rising edge.
- REQ-005 Port Reset, in, 1: asynchronous, active-low reset.
- REQ-006 Port clr_req, in, 1: pulse that requests a register-file scrub.
- REQ-007 Port req_valid, in, NREQ: per-requester write request.
- REQ-008 Port req_ready, out, NREQ: per-requester grant; a transfer occurs when valid and ready are both high.
- REQ-009 Port req_addr, in, NREQ*AW: flattened destination register numbers; requester i occupies slice [i*AW +: AW].
- REQ-010 Port req_data, in, NREQ*DW: flattened write data; requester i occupies slice [i*DW +: DW].
- REQ-011 Port req_pc, in, NREQ*DW: flattened instruction PC per request, used for the write trace.
- REQ-012 Ports WE (1), RW (AW), WD (DW), WPC (DW), out: registered GRF write port.
- REQ-013 Port busy, out, 1: high while a scrub is in progress.

Function
- REQ-014 The FSM SHALL have exactly two states, CLEAR and RUN.
- REQ-015 On leaving reset the FSM SHALL enter CLEAR with the scrub counter at 1.
- REQ-016 In CLEAR, each cycle SHALL drive WE=1, RW=counter, WD=0 and WPC=0, then increment the counter.
- REQ-017 CLEAR SHALL move to RUN after writing register 31, so a scrub takes exactly 31 cycles.
- REQ-018 In CLEAR, busy SHALL be 1 and all req_ready bits SHALL be 0.
- REQ-019 In RUN, clr_req=1 SHALL move the FSM to CLEAR on the next edge with the counter reset to 1, and no grant SHALL be issued in that cycle.
- REQ-020 clr_req asserted during CLEAR SHALL restart the counter at 1.
- REQ-021 In RUN, at most one req_ready bit SHALL be high per cycle, and only for a requester whose valid is high (one-hot grant).
- REQ-022 req_ready SHALL be combinational from req_valid and the arbiter state; there is no back-pressure beyond arbitration.
- REQ-023 Latency SHALL be one cycle: a transfer at edge N drives WE, RW, WD and WPC during cycle N+1.
- REQ-024 With no transfer, WE SHALL be 0 the next cycle, and RW, WD and WPC SHALL hold their last values.
- REQ-025 A granted request with addr 0 SHALL be accepted (ready=1) but SHALL produce WE=0, so $0 is never written.
- REQ-026 A requester whose valid stays high without a grant SHALL keep its addr, data and pc stable; the arbiter does not check this.

Reset
- REQ-027 While Reset=0: WE=0, RW=0, WD=0, WPC=0, req_ready=0, busy=1, FSM=CLEAR, counter=1, round-robin pointer=0.
- REQ-028 Reset asserted mid-scrub or mid-transfer SHALL immediately restore the REQ-027 values; any pending write SHALL be lost.

Configuration
- REQ-029 With GRF_WB_RR_EN defined, arbitration SHALL be round-robin: search starts at the pointer, and after a grant to index i the pointer becomes (i+1) mod NREQ.
- REQ-030 Without GRF_WB_RR_EN, arbitration SHALL be fixed priority 0 > 1 > 2, and no pointer register SHALL exist.

Structure
- REQ-031 Package grf_pkg SHALL hold AW, DW, NREQ, the requester index constants (REQ_ALU, REQ_LOAD, REQ_MDU), the FSM state typedef and SCRUB_LAST=31.
- REQ-032 Grant selection SHALL be in sub-module grf_wb_grant (inputs: valid vector and pointer; output: one-hot grant), containing both arbitration variants.

Verification
- REQ-033 Release Reset, no requests -> 31 cycles with WE=1, RW=1..31, WD=0 and busy=1; then busy=0 and WE=0.
- REQ-034 In RUN, valid=3'b011, ALU addr 5 data 0x1234, LOAD addr 6 data 0xBEEF, fixed priority -> ready=001, then WE/RW=5/WD=0x1234; LOAD granted the next cycle, then RW=6/WD=0xBEEF.
- REQ-035 GRF_WB_RR_EN defined, valid=3'b111 held for 6 cycles -> grant sequence 001, 010, 100, 001, 010, 100.
- REQ-036 MDU request with addr 0, data 0xFFFFFFFF -> ready[2]=1, and WE stays 0 the next cycle.
- REQ-037 clr_req at cycle 10 of RUN with valid=3'b001 -> ready=0 in that cycle, and a fresh 31-cycle scrub follows.
- REQ-038 Reset pulsed low at scrub cycle 15 -> all outputs take reset values asynchronously, and after release the scrub restarts at RW=1.
